// File: rtl/atu_pkg.sv
// Shared types and helpers for the angle tracking unit: FSM states, default
// resolution and the quadrature step decoder.
package atu_pkg;

    typedef enum logic [1:0] {
        UNHOMED  = 2'd0,
        ZEROING  = 2'd1,
        TRACKING = 2'd2
    } atu_state_t;

    localparam int ATU_COUNTS_PER_REV = 1006;

    typedef struct packed {
        logic signed [1:0] dir;
        logic              illegal;
    } step_t;

    // Position of an {A,B} pair along the clockwise Gray cycle 00->01->11->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic step_t step_dir(input logic [1:0] prev, input logic [1:0] curr);
        step_t      res;
        logic [1:0] delta;
        delta       = gray_idx(curr) - gray_idx(prev);
        res.dir     = 2'sd0;
        res.illegal = 1'b0;
        case (delta)
            2'd1:    res.dir     = 2'sb01;
            2'd3:    res.dir     = 2'sb11;
            2'd2:    res.illegal = 1'b1;
            default: res.dir     = 2'sd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/atu_if.sv
// Controller-facing bundle of the angle tracking unit: encoder inputs, home and
// monitor requests, and the reported angle/status.
interface atu_if #(
    parameter int ANGLE_W = 12
);
    logic               enc_a;
    logic               enc_b;
    logic               atu_reset;
    logic               atu_monitor;
    logic [ANGLE_W-1:0] current_angle;
    logic               angle_valid;
    logic               clockwise;
    logic               count_strobe;
    logic               quad_error;

    modport master (
        output enc_a, enc_b, atu_reset, atu_monitor,
        input  current_angle, angle_valid, clockwise, count_strobe, quad_error
    );

    modport slave (
        input  enc_a, enc_b, atu_reset, atu_monitor,
        output current_angle, angle_valid, clockwise, count_strobe, quad_error
    );
endinterface

// File: rtl/quad_input_filter.sv
// Per-channel encoder input conditioning: synchroniser chain followed by a
// stability counter that only lets a level through once it has held long enough.
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // The new level is accepted on the FILTER_LEN-th consecutive cycle of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/angle_tracking_unit.sv
// Quadrature decoder: filtered A/B pair -> wrapped angle count with homing FSM.
// state    | meaning
// UNHOMED  | angle not referenced; steps still counted, angle_valid=0
// ZEROING  | home request active; angle and quad_error forced to 0
// TRACKING | referenced; angle_valid follows atu_monitor
module angle_tracking_unit
    import atu_pkg::*;
#(
    parameter int COUNTS_PER_REV = ATU_COUNTS_PER_REV,
    parameter int ANGLE_W        = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4
) (
    input logic   clk,
    input logic   reset,
    atu_if.slave  bus
);
    localparam logic [ANGLE_W-1:0] MAX_ANGLE = ANGLE_W'(COUNTS_PER_REV - 1);

    atu_state_t         r_state;
    atu_state_t         w_state_next;
    logic               w_filt_a;
    logic               w_filt_b;
    logic [1:0]         w_curr;
    logic [1:0]         r_prev;
    step_t              w_step;
    logic [ANGLE_W-1:0] r_angle;
    logic [ANGLE_W-1:0] w_angle_next;
    logic               r_cw;
    logic               w_cw_next;
    logic               r_strobe;
    logic               r_err;
    logic               w_err_next;

    quad_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (bus.enc_a),
        .o_filt (w_filt_a)
    );

    quad_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (bus.enc_b),
        .o_filt (w_filt_b)
    );

    assign w_curr = {w_filt_a, w_filt_b};
    assign w_step = step_dir(r_prev, w_curr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= UNHOMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            UNHOMED: begin
                if (bus.atu_reset) w_state_next = ZEROING;
            end
            ZEROING: begin
                if (!bus.atu_reset) w_state_next = TRACKING;
            end
            TRACKING: begin
                if (bus.atu_reset)          w_state_next = ZEROING;
                else if (w_step.illegal)    w_state_next = UNHOMED;
            end
            default: w_state_next = UNHOMED;
        endcase
    end

    // Priority: home request, then illegal transition, then a normal step.
    always_comb begin
        w_angle_next = r_angle;
        w_cw_next    = r_cw;
        w_err_next   = r_err;
        if (r_state == ZEROING) begin
            w_angle_next = '0;
            w_err_next   = 1'b0;
        end else if (!bus.atu_reset) begin
            if (w_step.illegal) begin
                w_err_next = 1'b1;
            end else if (bus.atu_monitor && (w_step.dir != 2'sd0)) begin
                if (w_step.dir == 2'sb01) begin
                    w_cw_next    = 1'b1;
                    w_angle_next = (r_angle == MAX_ANGLE) ? '0 : r_angle + 1'b1;
                end else begin
                    w_cw_next    = 1'b0;
                    w_angle_next = (r_angle == '0) ? MAX_ANGLE : r_angle - 1'b1;
                end
            end
        end
    end

    // prev follows the filtered pair unconditionally so re-enabling never replays old motion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev   <= 2'b00;
            r_angle  <= '0;
            r_cw     <= 1'b0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_prev   <= w_curr;
            r_angle  <= w_angle_next;
            r_cw     <= w_cw_next;
            r_strobe <= (w_angle_next != r_angle);
            r_err    <= w_err_next;
        end
    end

    assign bus.current_angle = r_angle;
    assign bus.angle_valid   = (r_state == TRACKING) && bus.atu_monitor;
    assign bus.clockwise     = r_cw;
    assign bus.count_strobe  = r_strobe;
    assign bus.quad_error    = r_err;

endmodule
